// File: rtl/acc_drain_reader_if.sv
// Bus bundle for acc_drain_reader: accumulator read port and the
// valid/ready output stream. When ACC_CLR_ON_READ_EN is defined the bundle
// also carries the accumulator clear port (acc_clr_en / acc_clr_addr).
interface acc_drain_reader_if #(
  parameter int PARTIAL_SUM_WIDTH = 45,
  parameter int ADDR_WIDTH        = 3,
  parameter int OUT_WIDTH         = 8
);
  logic                         acc_rd_en;
  logic [ADDR_WIDTH-1:0]        acc_rd_addr;
  logic [PARTIAL_SUM_WIDTH-1:0] acc_rd_data;
  logic                         out_valid;
  logic                         out_ready;
  logic [OUT_WIDTH-1:0]         out_data;
  logic [ADDR_WIDTH-1:0]        out_addr;
  logic                         out_last;
`ifdef ACC_CLR_ON_READ_EN
  logic                         acc_clr_en;
  logic [ADDR_WIDTH-1:0]        acc_clr_addr;
`endif

  // Reader side: drives the read strobe and the output stream.
  modport master (
`ifdef ACC_CLR_ON_READ_EN
    output acc_clr_en, acc_clr_addr,
`endif
    output acc_rd_en, acc_rd_addr,
    input  acc_rd_data,
    output out_valid, out_data, out_addr, out_last,
    input  out_ready
  );

  // Accumulator bank / downstream side.
  modport slave (
`ifdef ACC_CLR_ON_READ_EN
    input  acc_clr_en, acc_clr_addr,
`endif
    input  acc_rd_en, acc_rd_addr,
    output acc_rd_data,
    input  out_valid, out_data, out_addr, out_last,
    output out_ready
  );
endinterface

// File: rtl/acc_drain_reader.sv
// acc_drain_reader: on start, reads accumulator entries 0..DEPTH-1 once each,
// requantises every partial sum (logical right shift, unsigned saturate) and
// streams the results through a 2-entry FIFO onto a valid/ready interface.
// Optional feature macro: ACC_CLR_ON_READ_EN -- adds acc_clr_en/acc_clr_addr,
// which trail each read by one cycle so the bank is cleared as it is drained.
module acc_drain_reader #(
  parameter int PARTIAL_SUM_WIDTH = 45,
  parameter int DEPTH             = 8,
  parameter int ADDR_WIDTH        = 3,
  parameter int OUT_WIDTH         = 8,
  parameter int SHIFT_WIDTH       = 6
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   start,
  input  logic [SHIFT_WIDTH-1:0] shift,
  output logic                   busy,
  output logic                   done,
  acc_drain_reader_if.master     bus
);

  typedef enum logic [1:0] {S_IDLE, S_READ, S_FLUSH} state_e;

  localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(DEPTH - 1);

  state_e                       state_q;
  logic                         busy_q;
  logic                         done_q;
  logic [SHIFT_WIDTH-1:0]       shift_q;
  logic [ADDR_WIDTH-1:0]        rd_addr_q;
  logic                         inflight_q;   // a read was issued last cycle
  logic [ADDR_WIDTH-1:0]        cap_addr_q;   // address of that read
  logic [OUT_WIDTH-1:0]         fifo_data_q [2];
  logic [ADDR_WIDTH-1:0]        fifo_addr_q [2];
  logic                         wr_ptr_q;
  logic                         rd_ptr_q;
  logic [1:0]                   count_q;

  logic                         pop;
  logic                         push;
  logic                         rd_en;
  logic [2:0]                   committed;
  logic [PARTIAL_SUM_WIDTH-1:0] shifted;
  logic [OUT_WIDTH-1:0]         quant;

  // Read throttle: FIFO occupancy after this cycle's pop plus the read whose
  // data lands this cycle must leave room for the read issued now.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    pop       = 1'b0;
    push      = inflight_q;
    committed = 3'd0;
    rd_en     = 1'b0;
    pop       = (count_q != 2'd0) && bus.out_ready;
    committed = {1'b0, count_q} - 3'(pop) + 3'(inflight_q);
    rd_en     = (state_q == S_READ) && (committed < 3'd2);
  end

  // Requantise the returning partial sum: logical shift then unsigned saturate.
  always_comb begin
    shifted = '0;
    quant   = '0;
    if (int'(shift_q) < PARTIAL_SUM_WIDTH) begin
      shifted = bus.acc_rd_data >> shift_q;
    end
    quant = (|shifted[PARTIAL_SUM_WIDTH-1:OUT_WIDTH]) ? {OUT_WIDTH{1'b1}}
                                                      : shifted[OUT_WIDTH-1:0];
  end

  // Control FSM: IDLE -> READ -> FLUSH -> IDLE, with registered busy/done.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    if (rst) begin
      state_q   <= S_IDLE;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      shift_q   <= '0;
      rd_addr_q <= '0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (start) begin
            state_q   <= S_READ;
            busy_q    <= 1'b1;
            shift_q   <= shift;
            rd_addr_q <= '0;
          end
        end
        S_READ: begin
          if (rd_en) begin
            if (rd_addr_q == LAST_ADDR) begin
              state_q <= S_FLUSH;
            end else begin
              rd_addr_q <= rd_addr_q + 1'b1;
            end
          end
        end
        S_FLUSH: begin
          if (pop && bus.out_last) begin
            state_q <= S_IDLE;
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  // Track the outstanding read so its data is captured one cycle later.
  always_ff @(posedge clk) begin
    if (rst) begin
      inflight_q <= 1'b0;
      cap_addr_q <= '0;
    end else begin
      inflight_q <= rd_en;
      if (rd_en) begin
        cap_addr_q <= rd_addr_q;
      end
    end
  end

  // 2-entry output FIFO holding requantised value and source index.
  always_ff @(posedge clk) begin
    if (rst) begin
      // NOTE: the two storage entries are reset so out_data/out_addr read as
      // zero after reset; at two entries this costs almost nothing.
      fifo_data_q <= '{default: '0};
      fifo_addr_q <= '{default: '0};
      wr_ptr_q    <= 1'b0;
      rd_ptr_q    <= 1'b0;
      count_q     <= 2'd0;
    end else begin
      if (push) begin
        fifo_data_q[wr_ptr_q] <= quant;
        fifo_addr_q[wr_ptr_q] <= cap_addr_q;
        wr_ptr_q              <= ~wr_ptr_q;
      end
      if (pop) begin
        rd_ptr_q <= ~rd_ptr_q;
      end
      count_q <= count_q + 2'(push) - 2'(pop);
    end
  end

  // The throttle guarantees no push into a full FIFO without a pop.
  assert property (@(posedge clk) disable iff (rst)
    !(push && !pop && (count_q == 2'd2)));

  assign busy            = busy_q;
  assign done            = done_q;
  assign bus.acc_rd_en   = rd_en;
  assign bus.acc_rd_addr = rd_addr_q;
  assign bus.out_valid   = (count_q != 2'd0);
  assign bus.out_data    = fifo_data_q[rd_ptr_q];
  assign bus.out_addr    = fifo_addr_q[rd_ptr_q];
  assign bus.out_last    = (count_q != 2'd0) && (fifo_addr_q[rd_ptr_q] == LAST_ADDR);

`ifdef ACC_CLR_ON_READ_EN
  // Clear strobe is the captured read, so it trails acc_rd_en by one cycle.
  assign bus.acc_clr_en   = inflight_q;
  assign bus.acc_clr_addr = cap_addr_q;
`endif

endmodule
